// File: rtl/kmeans_iter_engine.sv
// kmeans_iter_engine: self-iterating K-means engine with an internal point RAM and centroid registers.
// Ports: clk, rst (async, active-low); go starts a run when idle.
// Ports: pt_we/pt_addr/pt_data load the point RAM; cent_we/cent_addr/cent_data load the initial centroids.
// Ports: threshold, first/last_point_index and max_iter configure a run; they are latched on go.
// Ports: busy, done, converged and iter_count report status.
// Ports: rd_cent_addr/rd_cent_data give a combinational read of the centroid registers.
module kmeans_iter_engine #(
    parameter int WIDTH   = 13,
    parameter int DIM     = 7,
    parameter int K       = 8,
    parameter int NPOINTS = 512,
    parameter int PW      = $clog2(NPOINTS),
    parameter int KW      = $clog2(K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 pt_we,
    input  logic [PW-1:0]        pt_addr,
    input  logic [DIM*WIDTH-1:0] pt_data,
    input  logic                 cent_we,
    input  logic [KW-1:0]        cent_addr,
    input  logic [DIM*WIDTH-1:0] cent_data,
    input  logic [WIDTH-1:0]     threshold,
    input  logic [PW-1:0]        first_point_index,
    input  logic [PW-1:0]        last_point_index,
    input  logic [7:0]           max_iter,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [7:0]           iter_count,
    input  logic [KW-1:0]        rd_cent_addr,
    output logic [DIM*WIDTH-1:0] rd_cent_data
);
    localparam int DW  = WIDTH + $clog2(DIM);
    localparam int NW  = WIDTH + PW;
    localparam int MW  = WIDTH + 8;
    localparam int CW  = PW + 1;
    localparam int DDW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int BW  = $clog2(NW);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_EVAL, S_UPD, S_DIV, S_WB, S_CHECK, S_DONE} state_t;
    state_t               r_state;
    logic [DIM*WIDTH-1:0] r_mem [NPOINTS];
    logic [DIM*WIDTH-1:0] r_pt;
    logic [DIM*WIDTH-1:0] r_cent [K];
    logic [NW-1:0]        r_sum [K][DIM];
    logic [CW-1:0]        r_cnt [K];
    logic [WIDTH-1:0]     r_thr;
    logic [PW-1:0]        r_first, r_last, r_p;
    logic [7:0]           r_max, r_iter;
    logic [KW-1:0]        r_k, r_best;
    logic [DW-1:0]        r_best_d;
    logic [DDW-1:0]       r_d;
    logic [BW-1:0]        r_bit;
    logic [NW-1:0]        r_q;
    logic [CW-1:0]        r_rem;
    logic [MW-1:0]        r_move;
    logic                 r_busy, r_done, r_conv;
    logic [DW-1:0]        w_dist;
    logic                 w_take, w_ge, w_last_kd;
    logic [KW-1:0]        w_best;
    logic [CW:0]          w_rem_sh, w_rem_nx;
    logic [WIDTH-1:0]     w_new, w_old, w_diff;
    logic [MW:0]          w_mv;
    logic [7:0]           w_iter_nx;
    function automatic logic [WIDTH-1:0] absd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
    always_comb begin
        w_dist = '0;
        for (int d = 0; d < DIM; d++)
            w_dist = w_dist + DW'(absd(r_pt[d*WIDTH +: WIDTH], r_cent[r_k][d*WIDTH +: WIDTH]));
        // centroid 0 always seeds the search; later ones must be strictly closer
        w_take    = (r_k == '0) || (w_dist < r_best_d);
        w_best    = w_take ? r_k : r_best;
        w_rem_sh  = {r_rem, r_q[NW-1]};
        w_ge      = w_rem_sh >= (CW+1)'(r_cnt[r_k]);
        w_rem_nx  = w_ge ? w_rem_sh - (CW+1)'(r_cnt[r_k]) : w_rem_sh;
        w_new     = r_q[WIDTH-1:0];
        w_old     = r_cent[r_k][r_d*WIDTH +: WIDTH];
        w_diff    = absd(w_new, w_old);
        w_mv      = {1'b0, r_move} + (MW+1)'(w_diff);
        w_iter_nx = r_iter + 8'd1;
        w_last_kd = (r_k == KW'(K-1)) && (r_d == DDW'(DIM-1));
    end
    always_ff @(posedge clk) begin
        if (pt_we && r_state == S_IDLE) r_mem[pt_addr] <= pt_data;
        if (r_state == S_RD) r_pt <= r_mem[r_p];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_conv   <= 1'b0;
            r_iter   <= '0;
            r_thr    <= '0;
            r_first  <= '0;
            r_last   <= '0;
            r_max    <= '0;
            r_p      <= '0;
            r_k      <= '0;
            r_best   <= '0;
            r_best_d <= '0;
            r_d      <= '0;
            r_bit    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_move   <= '0;
            for (int k = 0; k < K; k++) begin
                r_cent[k] <= '0;
                r_cnt[k]  <= '0;
                for (int d = 0; d < DIM; d++) r_sum[k][d] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cent_we) r_cent[cent_addr] <= cent_data;
                    if (go) begin
                        r_thr   <= threshold;
                        r_first <= first_point_index;
                        r_last  <= last_point_index;
                        r_max   <= max_iter;
                        r_p     <= first_point_index;
                        r_iter  <= '0;
                        r_conv  <= 1'b0;
                        r_move  <= '0;
                        r_k     <= '0;
                        r_d     <= '0;
                        if (max_iter == 8'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= (first_point_index > last_point_index) ? S_UPD : S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_k     <= '0;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (w_take) begin
                        r_best   <= r_k;
                        r_best_d <= w_dist;
                    end
                    if (r_k == KW'(K-1)) begin
                        for (int d = 0; d < DIM; d++)
                            r_sum[w_best][d] <= r_sum[w_best][d] + NW'(r_pt[d*WIDTH +: WIDTH]);
                        r_cnt[w_best] <= r_cnt[w_best] + CW'(1);
                        r_k           <= '0;
                        r_p           <= r_p + PW'(1);
                        r_state       <= (r_p == r_last) ? S_UPD : S_RD;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_UPD: begin
                    // an empty cluster skips the divider and writes back its own value, moving by 0
                    r_q     <= (r_cnt[r_k] == '0) ? NW'(w_old) : r_sum[r_k][r_d];
                    r_rem   <= '0;
                    r_bit   <= '0;
                    r_state <= (r_cnt[r_k] == '0) ? S_WB : S_DIV;
                end
                S_DIV: begin
                    // restoring divide: the dividend shifts out of r_q's top while quotient bits enter below
                    r_q     <= {r_q[NW-2:0], w_ge};
                    r_rem   <= CW'(w_rem_nx);
                    r_bit   <= r_bit + BW'(1);
                    r_state <= (r_bit == BW'(NW-1)) ? S_WB : S_DIV;
                end
                S_WB: begin
                    r_cent[r_k][r_d*WIDTH +: WIDTH] <= w_new;
                    r_move  <= w_mv[MW] ? '1 : w_mv[MW-1:0];
                    r_d     <= (r_d == DDW'(DIM-1)) ? '0 : r_d + DDW'(1);
                    r_k     <= (r_d == DDW'(DIM-1)) ? r_k + KW'(1) : r_k;
                    r_state <= w_last_kd ? S_CHECK : S_UPD;
                end
                S_CHECK: begin
                    r_iter <= w_iter_nx;
                    r_move <= '0;
                    r_k    <= '0;
                    r_d    <= '0;
                    r_p    <= r_first;
                    for (int k = 0; k < K; k++) begin
                        r_cnt[k] <= '0;
                        for (int d = 0; d < DIM; d++) r_sum[k][d] <= '0;
                    end
                    if (r_move <= MW'(r_thr) || w_iter_nx == r_max) begin
                        r_conv  <= (r_move <= MW'(r_thr));
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RD;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy         = r_busy;
    assign done         = r_done;
    assign converged    = r_conv;
    assign iter_count   = r_iter;
    assign rd_cent_data = r_cent[rd_cent_addr];
endmodule

// File: tb/tb_kmeans_iter_engine.sv
// tb_kmeans_iter_engine: scoreboard bench for kmeans_iter_engine with directed hand-computed cases.
module tb_kmeans_iter_engine;
    localparam int W = 13, D = 7, K = 8, PW = 9, KW = 3;
    logic           clk = 1'b0, rst = 1'b0, go = 1'b0, pt_we = 1'b0, cent_we = 1'b0;
    logic [PW-1:0]  pt_addr = '0, first_point_index = '0, last_point_index = '0;
    logic [D*W-1:0] pt_data = '0, cent_data = '0;
    logic [KW-1:0]  cent_addr = '0, rd_cent_addr = '0;
    logic [W-1:0]   threshold = '0;
    logic [7:0]     max_iter = '0;
    logic           busy, done, converged;
    logic [7:0]     iter_count;
    logic [D*W-1:0] rd_cent_data;
    typedef struct packed {
        logic           is_done;
        logic           conv;
        logic [7:0]     iter;
        logic [K*W-1:0] c;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_fail = 0, snap_req = 0;
    always #5 clk = ~clk;
    kmeans_iter_engine dut (
        .clk(clk), .rst(rst), .go(go), .pt_we(pt_we), .pt_addr(pt_addr), .pt_data(pt_data),
        .cent_we(cent_we), .cent_addr(cent_addr), .cent_data(cent_data), .threshold(threshold),
        .first_point_index(first_point_index), .last_point_index(last_point_index),
        .max_iter(max_iter), .busy(busy), .done(done), .converged(converged),
        .iter_count(iter_count), .rd_cent_addr(rd_cent_addr), .rd_cent_data(rd_cent_data)
    );
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [K*W-1:0] cv(input int c0, input int c1, input int rest);
        logic [K*W-1:0] r;
        for (int k = 0; k < K; k++) r[k*W +: W] = W'((k == 0) ? c0 : (k == 1) ? c1 : rest);
        return r;
    endfunction
    task automatic expect_ev(input logic is_done, input logic conv, input int iter, input logic [K*W-1:0] c);
        exp_t e;
        e.is_done = is_done;
        e.conv    = conv;
        e.iter    = 8'(iter);
        e.c       = c;
        q.push_back(e);
    endtask
    task automatic wr_pt(input int a, input int v);
        pt_addr = PW'(a);
        pt_data = {D{W'(v)}};
        pt_we   = 1'b1;
        @(negedge clk);
        pt_we   = 1'b0;
    endtask
    task automatic wr_cent(input int a, input int v);
        cent_addr = KW'(a);
        cent_data = {D{W'(v)}};
        cent_we   = 1'b1;
        @(negedge clk);
        cent_we   = 1'b0;
    endtask
    task automatic init_cents(input int c0, input int c1);
        wr_cent(0, c0);
        wr_cent(1, c1);
        for (int k = 2; k < K; k++) wr_cent(k, 8191);
    endtask
    task automatic start(input int f, input int l, input int thr, input int mi);
        first_point_index = PW'(f);
        last_point_index  = PW'(l);
        threshold         = W'(thr);
        max_iter          = 8'(mi);
        go                = 1'b1;
        @(negedge clk);
        go                = 1'b0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                repeat (12) @(negedge clk);
                return;
            end
        end
        $display("FAIL wait_done: no done pulse within 20000 cycles");
        $fatal(1, "timeout");
    endtask
    initial begin : monitor
        int   seen;
        exp_t e;
        seen = 0;
        forever begin
            @(negedge clk);
            if (done || snap_req != seen) begin
                if (!done) seen++;
                chk("event_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("event_kind_done", done, e.is_done);
                    chk("converged", converged, e.conv);
                    chk("iter_count", iter_count, e.iter);
                    chk("busy_at_event", busy, 0);
                    for (int k = 0; k < K; k++) begin
                        rd_cent_addr = KW'(k);
                        #1;
                        chk($sformatf("centroid%0d", k), rd_cent_data, {D{e.c[k*W +: W]}});
                    end
                end
            end
        end
    end
    initial begin : stim
        int nd, nb;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_converged", converged, 0);
        chk("reset_iter", iter_count, 0);
        expect_ev(1'b0, 1'b0, 0, cv(0, 0, 0));
        snap_req++;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) wr_pt(i, (i < 4) ? 10 : 1000);
        init_cents(0, 1500);
        expect_ev(1'b1, 1'b1, 2, cv(10, 1000, 8191));
        start(0, 7, 0, 10);
        wait_done();
        init_cents(0, 1500);
        expect_ev(1'b1, 1'b0, 1, cv(10, 1000, 8191));
        start(0, 7, 0, 1);
        wait_done();
        wr_pt(0, 50);
        init_cents(0, 100);
        expect_ev(1'b1, 1'b1, 2, cv(50, 100, 8191));
        start(0, 0, 0, 5);
        wait_done();
        expect_ev(1'b1, 1'b1, 1, cv(50, 100, 8191));
        start(5, 3, 0, 5);
        wait_done();
        wr_pt(0, 10);
        init_cents(0, 1500);
        start(0, 7, 0, 10);
        repeat (150) @(negedge clk);
        chk("busy_mid_update", busy, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("busy_in_reset", busy, 0);
        chk("done_in_reset", done, 0);
        expect_ev(1'b0, 1'b0, 0, cv(0, 0, 0));
        snap_req++;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (700) @(negedge clk);
        chk("busy_after_abort", busy, 0);
        init_cents(0, 1500);
        expect_ev(1'b1, 1'b1, 2, cv(10, 1000, 8191));
        start(0, 7, 0, 10);
        wait_done();
        init_cents(0, 1500);
        expect_ev(1'b1, 1'b1, 2, cv(10, 1000, 8191));
        start(0, 7, 0, 10);
        repeat (20) @(negedge clk);
        pt_addr   = '0;
        pt_data   = {D{W'(4000)}};
        pt_we     = 1'b1;
        cent_addr = '0;
        cent_data = {D{W'(4000)}};
        cent_we   = 1'b1;
        max_iter  = 8'd0;
        go        = 1'b1;
        @(negedge clk);
        pt_we     = 1'b0;
        cent_we   = 1'b0;
        go        = 1'b0;
        wait_done();
        expect_ev(1'b1, 1'b0, 0, cv(10, 1000, 8191));
        first_point_index = '0;
        last_point_index  = PW'(7);
        max_iter          = 8'd0;
        go                = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            go = 1'b0;
            nd += int'(done);
            nb += int'(busy);
        end
        chk("max_iter0_done_pulses", nd, 1);
        chk("max_iter0_busy_cycles", nb, 0);
        repeat (12) @(negedge clk);
        init_cents(0, 1500);
        expect_ev(1'b1, 1'b1, 2, cv(10, 1000, 8191));
        start(0, 7, 0, 10);
        wait_done();
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/kmeans_iter_engine.md
Name: kmeans_iter_engine

Overview:
- Parametrised, self-iterating K-means clustering engine. Successor to the fixed-size Kmeans reference datapath (13-bit, 8 centroids x 7 dims, 3584-word flat matrix).
- Holds points in an internal RAM and centroids in registers. Repeats assign/update passes until total centroid movement is at or below the threshold, or an iteration cap is hit.
- Sits between the host load path and the scoreboard; the scoreboard reads final centroids through an addressed read port.

Parameters:
- WIDTH, 13, bits per coordinate (unsigned).
- DIM, 7, coordinates per point/centroid.
- K, 8, number of centroids.
- NPOINTS, 512, point RAM depth.
- PW, $clog2(NPOINTS), point index width (derived).
- KW, $clog2(K), centroid index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- go  in  1  start pulse; sampled in IDLE only
- pt_we  in  1  point RAM write strobe
- pt_addr  in  PW  point write address
- pt_data  in  DIM*WIDTH  point, dim0 in LSBs
- cent_we  in  1  initial centroid write strobe
- cent_addr  in  KW  centroid write address
- cent_data  in  DIM*WIDTH  centroid value
- threshold  in  WIDTH  convergence threshold
- first_point_index  in  PW  first point of range, inclusive
- last_point_index  in  PW  last point of range, inclusive
- max_iter  in  8  iteration cap
- busy  out  1  high from go acceptance until done
- done  out  1  one-cycle completion pulse
- converged  out  1  valid from done until next go
- iter_count  out  8  completed iterations
- rd_cent_addr  in  KW  result read address
- rd_cent_data  out  DIM*WIDTH  combinational read of centroid register

Behaviour:
- Reset (rst=0, async): FSM to IDLE; busy, done, converged, iter_count, all centroid registers and accumulators cleared to 0. Point RAM is not cleared.
- IDLE:
  - pt_we / cent_we write in the cycle asserted.
  - go=1 latches threshold, both indices and max_iter, sets busy next cycle, clears iter_count and converged.
  - go with max_iter=0: done pulses, busy stays 0, converged=0, centroids unchanged.
- Writes while busy=1 are ignored. go while busy=1 is ignored.
- ASSIGN:
  - For each point p from first to last: evaluate centroids 0..K-1, one per cycle.
  - Distance is L1: sum over d of |p_d - c_d|, width WIDTH+$clog2(DIM), no overflow possible.
  - Strictly-less comparison, so ties go to the lowest index.
  - After centroid K-1, add the point into sum[best][d] (WIDTH+PW bits) and increment cnt[best] (PW+1 bits).
  - Cost: (last-first+1)*K cycles plus 1 cycle RAM read latency per point.
  - If first > last, the range is empty: skip directly to UPDATE with all counts 0.
- UPDATE:
  - For each centroid k and dim d: if cnt[k]=0, keep old value.
  - Otherwise new = floor(sum/cnt) via a sequential restoring divider, 1 quotient bit per cycle, WIDTH+PW cycles per coordinate.
  - Accumulate movement += |new - old|, saturating at 2^(WIDTH+8)-1.
  - Write new value after computing the difference.
- CHECK:
  - iter_count += 1; clear sums and counts.
  - If movement <= threshold: converged=1, go to DONE.
  - Else if iter_count == max_iter: converged=0, go to DONE.
  - Else go to ASSIGN.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. converged and iter_count hold until next go.
- rd_cent_data is always live. During busy it shows intermediate centroids.
- rst low mid-operation aborts immediately; no done pulse.

Test Plan:
- Setup for the two-cluster cases:
  - Points 0-3 all coords 10; points 4-7 all coords 1000; range 0..7.
  - c0=all 0, c1=all 1500, c2..c7=all 8191.
- Two-cluster run, threshold=0, max_iter=10: iteration 1 gives c0=10, c1=1000, movement 3570; iteration 2 movement 0. Expect converged=1, iter_count=2, c2..c7 unchanged at 8191.
- Iteration cap: same setup, max_iter=1 -> done after 1 iteration, converged=0, c0=10, c1=1000.
- Tie: point all coords 50, c0=all 0, c1=all 100, range 0..0 -> point goes to c0; c0=all 50, c1 stays all 100.
- Empty range: first=5, last=3 -> converged=1, iter_count=1, all centroids unchanged.
- Reset during UPDATE: drop rst for 1 cycle -> busy=0 immediately, centroids all 0, no done. Reload and rerun the two-cluster case -> same result as the first case.
- Protocol: pt_we and go asserted while busy -> RAM contents and results unaffected. max_iter=0 -> single done pulse, busy never high.
